// File: rtl/sc_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sc_mul_pkg
// Purpose : Shared definitions for the sequential shift-add multiplier:
//           default operand width and the controller state encoding.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package sc_mul_pkg;

  // Default operand/result width of the multiplier.
  localparam int unsigned SC_MUL_DATAWIDTH_DEFAULT = 32;

  // Controller state encoding.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } sc_mul_state_e;

endpackage : sc_mul_pkg
`default_nettype wire

// File: rtl/sc_mul_seq_dp.sv
`default_nettype none
// ============================================================================
// Module  : sc_mul_seq_dp
// Purpose : Shift-add multiplier datapath. Holds the double-width
//           accumulator, the zero-extended multiplicand shift register,
//           the multiplier shift register and the bit counter.
// Ports   : clk_i   - clock, rising edge
//           rst_i   - synchronous active-high reset
//           load_i  - capture operands, clear accumulator and counter
//           step_i  - process one multiplier bit
//           a_i     - multiplicand
//           b_i     - multiplier
//           prod_o  - accumulator value after the current bit is added
//           last_o  - the bit being processed this cycle is the final one
// Revision: 1.0 - initial release
// ============================================================================
module sc_mul_seq_dp #(
  parameter int unsigned DATAWIDTH_BUS = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       load_i,
  input  logic                       step_i,
  input  logic [DATAWIDTH_BUS-1:0]   a_i,
  input  logic [DATAWIDTH_BUS-1:0]   b_i,
  output logic [2*DATAWIDTH_BUS-1:0] prod_o,
  output logic                       last_o
);

  localparam int unsigned CNTWIDTH = $clog2(DATAWIDTH_BUS) + 1;

  logic [2*DATAWIDTH_BUS-1:0] acc_q,   acc_d;
  logic [2*DATAWIDTH_BUS-1:0] mcand_q, mcand_d;
  logic [DATAWIDTH_BUS-1:0]   mplr_q,  mplr_d;
  logic [CNTWIDTH-1:0]        cnt_q,   cnt_d;
  logic [2*DATAWIDTH_BUS-1:0] sum_w;

  // Full double-width add so no carry is ever dropped.
  assign sum_w  = acc_q + (mplr_q[0] ? mcand_q : '0);
  assign prod_o = sum_w;
  assign last_o = (cnt_q == CNTWIDTH'(DATAWIDTH_BUS - 1));

  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      acc_d   = '0;
      mcand_d = {{DATAWIDTH_BUS{1'b0}}, a_i};
      mplr_d  = b_i;
      cnt_d   = '0;
    end else if (step_i) begin
      acc_d   = sum_w;
      mcand_d = mcand_q << 1;
      mplr_d  = mplr_q >> 1;
      cnt_d   = cnt_q + CNTWIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule : sc_mul_seq_dp
`default_nettype wire

// File: rtl/sc_mul_seq.sv
`default_nettype none
// ============================================================================
// Module  : sc_mul_seq
// Purpose : Sequential unsigned shift-add multiplier, one multiplier bit per
//           clock, fixed latency. Result is the product mod 2^DATAWIDTH_BUS,
//           returned to a register bus with a one-cycle active-low load.
// Ports   : SC_MulSEQ_CLOCK_50      - clock, rising edge
//           SC_MulSEQ_RESET_InHigh  - synchronous active-high reset
//           SC_MulSEQ_start_InLow   - start request, active-low, level
//           SC_MulSEQ_dataA_InBus   - multiplicand
//           SC_MulSEQ_dataB_InBus   - multiplier
//           SC_MulSEQ_result_OutBus - low half of last completed product
//           SC_MulSEQ_load_OutLow   - active-low destination write strobe
//           SC_MulSEQ_busy_Out      - operation in progress
//           SC_MulSEQ_overflow_Out  - upper half of last product nonzero
// Revision: 1.0 - initial release
// ============================================================================
module sc_mul_seq
  import sc_mul_pkg::*;
#(
  parameter int unsigned DATAWIDTH_BUS = SC_MUL_DATAWIDTH_DEFAULT
) (
  input  logic                     SC_MulSEQ_CLOCK_50,
  input  logic                     SC_MulSEQ_RESET_InHigh,
  input  logic                     SC_MulSEQ_start_InLow,
  input  logic [DATAWIDTH_BUS-1:0] SC_MulSEQ_dataA_InBus,
  input  logic [DATAWIDTH_BUS-1:0] SC_MulSEQ_dataB_InBus,
  output logic [DATAWIDTH_BUS-1:0] SC_MulSEQ_result_OutBus,
  output logic                     SC_MulSEQ_load_OutLow,
  output logic                     SC_MulSEQ_busy_Out,
  output logic                     SC_MulSEQ_overflow_Out
);

  sc_mul_state_e              state_q, state_d;
  logic                       load_en_w;
  logic                       step_en_w;
  logic                       last_w;
  logic [2*DATAWIDTH_BUS-1:0] prod_w;
  logic [DATAWIDTH_BUS-1:0]   result_q;
  logic                       overflow_q;

  sc_mul_seq_dp #(
    .DATAWIDTH_BUS (DATAWIDTH_BUS)
  ) u_dp (
    .clk_i  (SC_MulSEQ_CLOCK_50),
    .rst_i  (SC_MulSEQ_RESET_InHigh),
    .load_i (load_en_w),
    .step_i (step_en_w),
    .a_i    (SC_MulSEQ_dataA_InBus),
    .b_i    (SC_MulSEQ_dataB_InBus),
    .prod_o (prod_w),
    .last_o (last_w)
  );

  // Next-state and datapath enables.
  always_comb begin
    state_d   = state_q;
    load_en_w = 1'b0;
    step_en_w = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!SC_MulSEQ_start_InLow) begin
          load_en_w = 1'b1;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        step_en_w = 1'b1;
        if (last_w) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge SC_MulSEQ_CLOCK_50) begin
    if (SC_MulSEQ_RESET_InHigh) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Result registers only update on the final bit, so partial sums are
  // never visible and the last value holds until the next completion.
  always_ff @(posedge SC_MulSEQ_CLOCK_50) begin
    if (SC_MulSEQ_RESET_InHigh) begin
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else if (step_en_w && last_w) begin
      result_q   <= prod_w[DATAWIDTH_BUS-1:0];
      overflow_q <= |prod_w[2*DATAWIDTH_BUS-1:DATAWIDTH_BUS];
    end
  end

  assign SC_MulSEQ_result_OutBus = result_q;
  assign SC_MulSEQ_overflow_Out  = overflow_q;
  assign SC_MulSEQ_load_OutLow   = (state_q != S_DONE);
  assign SC_MulSEQ_busy_Out      = (state_q == S_RUN) || (state_q == S_DONE);

endmodule : sc_mul_seq
`default_nettype wire

// File: tb/tb_sc_mul_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_sc_mul_seq
// Purpose : Directed self-checking bench for sc_mul_seq (32-bit build).
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_sc_mul_seq;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic         load_n;
  logic         busy;
  logic         ovf;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  sc_mul_seq #(
    .DATAWIDTH_BUS (W)
  ) dut (
    .SC_MulSEQ_CLOCK_50      (clk),
    .SC_MulSEQ_RESET_InHigh  (rst),
    .SC_MulSEQ_start_InLow   (start_n),
    .SC_MulSEQ_dataA_InBus   (a),
    .SC_MulSEQ_dataB_InBus   (b),
    .SC_MulSEQ_result_OutBus (result),
    .SC_MulSEQ_load_OutLow   (load_n),
    .SC_MulSEQ_busy_Out      (busy),
    .SC_MulSEQ_overflow_Out  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Launch one operation and follow it to its strobe. Inputs change on the
  // falling edge; outputs are sampled on the falling edge.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] exp_res, input logic exp_ovf);
    int k;
    int n;
    @(negedge clk);
    a = av; b = bv; start_n = 1'b0;
    @(negedge clk);
    start_n = 1'b1;
    k = cyc;
    check_eq({tag, "_busy_rise"}, 64'(busy), 64'd1);
    n = 0;
    while (load_n === 1'b1 && n < 3 * W) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_latency"}, 64'(cyc - k), 64'(W));
    check_eq({tag, "_result"}, 64'(result), 64'(exp_res));
    check_eq({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
    @(negedge clk);
    check_eq({tag, "_strobe_1cyc"}, 64'(load_n), 64'd1);
    check_eq({tag, "_busy_fall"}, 64'(busy), 64'd0);
  endtask

  initial begin : main
    int strobes;
    int lat;
    int k;
    int s_cyc [3];
    int ns;
    int n;

    rst = 1'b1; start_n = 1'b1; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_result", 64'(result), 64'd0);
    check_eq("rst_ovf", 64'(ovf), 64'd0);
    check_eq("rst_load", 64'(load_n), 64'd1);
    check_eq("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;

    // Basic products and overflow cases.
    run_op("m3x5", 32'd3, 32'd5, 32'h0000000F, 1'b0);
    run_op("mffx2", 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b1);
    run_op("m2p16sq", 32'h00010000, 32'h00010000, 32'h00000000, 1'b1);
    run_op("m0xdead", 32'd0, 32'hDEADBEEF, 32'h00000000, 1'b0);

    // Second start and operand changes during RUN are ignored.
    @(negedge clk);
    a = 32'd7; b = 32'd6; start_n = 1'b0;
    @(negedge clk);
    start_n = 1'b1;
    k = cyc;
    repeat (9) @(negedge clk);
    a = 32'd9; b = 32'd9; start_n = 1'b0;
    @(negedge clk);
    start_n = 1'b1;
    check_eq("ign_result_hold", 64'(result), 64'd0);
    strobes = 0; lat = -1;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (load_n === 1'b0) begin
        strobes++;
        if (lat < 0) lat = cyc - k;
      end
    end
    check_eq("ign_strobes", 64'(strobes), 64'd1);
    check_eq("ign_latency", 64'(lat), 64'(W));
    check_eq("ign_result", 64'(result), 64'd42);

    // Reset mid-operation aborts without a strobe.
    @(negedge clk);
    a = 32'd3; b = 32'd5; start_n = 1'b0;
    @(negedge clk);
    start_n = 1'b1;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_result", 64'(result), 64'd0);
    check_eq("abort_load", 64'(load_n), 64'd1);
    strobes = 0;
    for (int i = 0; i < W + 8; i++) begin
      @(negedge clk);
      if (load_n === 1'b0 || busy === 1'b1) strobes++;
    end
    check_eq("abort_no_strobe", 64'(strobes), 64'd0);
    run_op("m2x2", 32'd2, 32'd2, 32'd4, 1'b0);

    // Start held low: back-to-back operations.
    @(negedge clk);
    a = 32'd4; b = 32'd4; start_n = 1'b0;
    ns = 0; n = 0;
    while (ns < 3 && n < 4 * (W + 2)) begin
      @(negedge clk);
      n++;
      if (load_n === 1'b0) begin
        s_cyc[ns] = cyc;
        check_eq("b2b_result", 64'(result), 64'd16);
        ns++;
      end
    end
    start_n = 1'b1;
    check_eq("b2b_count", 64'(ns), 64'd3);
    if (ns == 3) begin
      check_eq("b2b_space1", 64'(s_cyc[1] - s_cyc[0]), 64'(W + 2));
      check_eq("b2b_space2", 64'(s_cyc[2] - s_cyc[1]), 64'(W + 2));
    end
    n = 0;
    while (busy !== 1'b0 && n < 2 * W + 8) begin
      @(negedge clk);
      n++;
    end
    check_eq("final_idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sc_mul_seq
`default_nettype wire
